// File: rtl/als_sample_sequencer_pkg.sv
// rtl/als_sample_sequencer_pkg.sv - shared types and frame constants for the ALS sampling sequencer
package als_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_REQ,
    ST_WAIT_DONE,
    ST_ACCUM,
    ST_PUBLISH
  } als_state_t;

  // Raw SPI frame width and the light-value field inside it.
  localparam int FRAME_W = 16;
  localparam int ALS_MSB = 12;
  localparam int ALS_LSB = 5;
  localparam int ALS_W   = 8;

endpackage

// File: rtl/als_sample_sequencer_if.sv
// rtl/als_sample_sequencer_if.sv - conversion handshake between the sequencer and the SPI controller
//   start : one-cycle conversion request (sequencer -> controller)
//   done  : one-cycle completion pulse (controller -> sequencer)
//   frame : raw SPI frame, valid while done is high
interface als_sample_sequencer_if;
  import als_pkg::*;

  logic               start;
  logic               done;
  logic [FRAME_W-1:0] frame;

  modport master (output start, input done, input frame);
  modport slave  (input start, output done, output frame);
endinterface

// File: rtl/als_sample_sequencer_period_timer.sv
// rtl/als_sample_sequencer_period_timer.sv - sample period down-counter with reload and tick
//   clk, rst : clock, asynchronous active-low reset
//   load     : load PERIOD-1 (start of a fresh period)
//   clear    : force the counter to zero
//   run      : count down while high
//   tick     : high in the cycle the running counter is at zero
module als_period_timer #(
  parameter int PERIOD = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      // Reload in the tick cycle so ticks are exactly PERIOD clocks apart.
      cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
    end
  end

  assign tick = run && (cnt == '0);

endmodule

// File: rtl/als_sample_sequencer.sv
// rtl/als_sample_sequencer.sv - periodic PmodALS conversion scheduler with sample averaging
//   clk, rst    : clock, asynchronous active-low reset
//   en          : sampling enable
//   spi         : conversion handshake to the SPI controller (start/done/frame)
//   avg         : latest published average, held between updates
//   avg_valid   : one-cycle strobe in the cycle avg updates
//   busy        : conversion outstanding (start until done or timeout)
//   timeout_err : sticky, a conversion was abandoned
//   overrun     : sticky, a period tick arrived while busy
module als_sample_sequencer
  import als_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 100000,
  parameter int AVG_LOG2      = 2,
  parameter int TIMEOUT       = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  als_sample_sequencer_if.master spi,
  output logic [ALS_W-1:0]       avg,
  output logic                   avg_valid,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   overrun
);

  localparam int ACC_W = ALS_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(1 << AVG_LOG2);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

  als_state_t       state, state_nx;
  logic             tick;
  logic             start_c;
  logic             wd_fire;
  logic             drop_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [ALS_W-1:0] sample_q;
  logic [WD_W-1:0]  wd_q;

  als_period_timer #(
    .PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state == ST_IDLE && en),
    .clear(state == ST_IDLE && !en),
    .run  (state != ST_IDLE && en),
    .tick (tick)
  );

  assign acc_sum = acc_q + ACC_W'(sample_q);
  assign cnt_inc = cnt_q + CNT_W'(1);
  // wd_q holds the number of cycles since start; done in the last cycle still wins.
  assign wd_fire = (state == ST_WAIT_DONE) && !spi.done && (wd_q == WD_LAST);
  assign spi.start = start_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    start_c   = 1'b0;
    busy      = 1'b0;
    avg_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nx = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (!en)       state_nx = ST_IDLE;
        else if (tick) state_nx = ST_REQ;
      end
      ST_REQ: begin
        start_c  = 1'b1;
        busy     = 1'b1;
        state_nx = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        busy = 1'b1;
        // A conversion overlapping an en drop is still awaited, then discarded.
        if (spi.done || wd_fire) begin
          if (drop_q || !en) state_nx = ST_IDLE;
          else if (spi.done) state_nx = ST_ACCUM;
          else               state_nx = ST_WAIT_TICK;
        end
      end
      ST_ACCUM: begin
        state_nx = (cnt_inc == N_SAMPLES) ? ST_PUBLISH : ST_WAIT_TICK;
      end
      ST_PUBLISH: begin
        avg_valid = 1'b1;
        state_nx  = ST_WAIT_TICK;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sample_q    <= '0;
      wd_q        <= '0;
      drop_q      <= 1'b0;
      avg         <= '0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (tick && busy) overrun     <= 1'b1;
      if (wd_fire)      timeout_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          acc_q  <= '0;
          cnt_q  <= '0;
          drop_q <= 1'b0;
        end
        ST_REQ: begin
          wd_q <= WD_W'(1);
          if (!en) drop_q <= 1'b1;
        end
        ST_WAIT_DONE: begin
          wd_q <= wd_q + WD_W'(1);
          if (!en) drop_q <= 1'b1;
          if (spi.done) sample_q <= spi.frame[ALS_MSB:ALS_LSB];
        end
        ST_ACCUM: begin
          acc_q <= acc_sum;
          cnt_q <= cnt_inc;
          // Loaded here so avg is already current in the PUBLISH cycle.
          if (cnt_inc == N_SAMPLES) avg <= acc_sum[AVG_LOG2 +: ALS_W];
        end
        ST_PUBLISH: begin
          acc_q <= '0;
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_als_sample_sequencer.sv
// tb/tb_als_sample_sequencer.sv - bench for als_sample_sequencer with SPI controller models
module tb_als_sample_sequencer;

  localparam int P   = 100;
  localparam int L   = 2;
  localparam int TO  = 64;
  localparam int TO2 = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en0 = 1'b0;
  logic en1 = 1'b0;
  always #5 clk = ~clk;

  als_sample_sequencer_if bus0();
  als_sample_sequencer_if bus1();

  logic [7:0] avg0, avg1;
  logic av0, av1, busy0, busy1, te0, te1, ov0, ov1;

  als_sample_sequencer #(.SAMPLE_PERIOD(P), .AVG_LOG2(L), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en0), .spi(bus0), .avg(avg0), .avg_valid(av0),
    .busy(busy0), .timeout_err(te0), .overrun(ov0));

  als_sample_sequencer #(.SAMPLE_PERIOD(P), .AVG_LOG2(L), .TIMEOUT(TO2)) dut2 (
    .clk(clk), .rst(rst), .en(en1), .spi(bus1), .avg(avg1), .avg_valid(av1),
    .busy(busy1), .timeout_err(te1), .overrun(ov1));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI controller model + monitor for dut
  int          delay0 = 40;
  int          withhold0 = 0;
  int          rem0 = 0;
  bit          pend0 = 0;
  bit          pbusy0 = 0;
  logic [15:0] frames0[$];
  int          starts0[$], dones0[$], avt0[$], busyfall0[$];
  logic [7:0]  avv0[$];

  always @(negedge clk) begin
    if (!rst) begin
      pend0 = 0;
      bus0.done = 1'b0;
      bus0.frame = '0;
    end else begin
      bus0.done = 1'b0;
      if (pend0) begin
        rem0--;
        if (rem0 == 0) begin
          pend0 = 0;
          bus0.done = 1'b1;
          bus0.frame = (frames0.size() > 0) ? frames0.pop_front() : 16'($urandom);
          dones0.push_back(cyc);
        end
      end
      if (bus0.start) begin
        starts0.push_back(cyc);
        if (withhold0 > 0) withhold0--;
        else begin pend0 = 1; rem0 = delay0; end
      end
      if (av0) begin avt0.push_back(cyc); avv0.push_back(avg0); end
      if (pbusy0 && !busy0) busyfall0.push_back(cyc);
    end
    pbusy0 = busy0;
  end

  // SPI controller model + monitor for dut2
  int delay1 = 120;
  int rem1 = 0;
  bit pend1 = 0;
  int starts1[$];

  always @(negedge clk) begin
    if (!rst) begin
      pend1 = 0;
      bus1.done = 1'b0;
      bus1.frame = '0;
    end else begin
      bus1.done = 1'b0;
      if (pend1) begin
        rem1--;
        if (rem1 == 0) begin
          pend1 = 0;
          bus1.done = 1'b1;
          bus1.frame = 16'($urandom);
        end
      end
      if (bus1.start) begin
        starts1.push_back(cyc);
        pend1 = 1;
        rem1 = delay1;
      end
    end
  end

  function automatic logic [15:0] mkf(input int s);
    return 16'(($urandom & 32'hE01F) | ((s & 255) << 5));
  endfunction

  // Reference: mean of the light field over one window, truncated.
  function automatic logic [7:0] ref_avg(input logic [15:0] f [4]);
    int s = 0;
    for (int i = 0; i < 4; i++) s += (int'(f[i]) >> 5) & 255;
    return 8'(s / (1 << L));
  endfunction

  task automatic clear_mon0;
    starts0.delete(); dones0.delete(); avt0.delete(); avv0.delete(); busyfall0.delete();
  endtask

  task automatic stop0;
    en0 = 1'b0;
    repeat (200) @(negedge clk);
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus0.start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", bus0.start); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
    total++; if (avg0 !== 8'd0) begin bad++; $display("FAIL reset_avg: got %0d want 0", avg0); end
    total++; if (av0 !== 1'b0) begin bad++; $display("FAIL reset_avg_valid: got %b want 0", av0); end
    total++; if (te0 !== 1'b0 || ov0 !== 1'b0) begin bad++; $display("FAIL reset_sticky: got te=%b ov=%b want 0 0", te0, ov0); end
    rst = 1'b1;
    repeat (150) @(negedge clk);
    total++; if (starts0.size() != 0) begin bad++; $display("FAIL idle_no_start: got %0d starts want 0", starts0.size()); end
  endtask

  task automatic test_basic;
    logic [15:0] f [4];
    int samp [4] = '{10, 20, 30, 40};
    int c;
    logic [7:0] exp;
    frames0.delete(); clear_mon0();
    for (int i = 0; i < 4; i++) begin f[i] = mkf(samp[i]); frames0.push_back(f[i]); end
    exp = ref_avg(f);
    @(negedge clk); en0 = 1'b1; c = cyc;
    for (int i = 0; i < 700 && avt0.size() < 1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    total++; if (avt0.size() != 1) begin bad++; $display("FAIL basic_av_count: got %0d want 1", avt0.size()); end
    total++; if (avv0.size() < 1 || avv0[0] !== exp) begin bad++; $display("FAIL basic_avg: got %0d want %0d", avv0.size() ? avv0[0] : 8'd0, exp); end
    total++; if (starts0.size() != 4 || starts0[0] != c + P + 1) begin bad++; $display("FAIL basic_first_start: got n=%0d t=%0d want n=4 t=%0d", starts0.size(), starts0.size() ? starts0[0] - c : -1, P + 1); end
    for (int i = 1; i < 4; i++) begin
      total++; if (starts0.size() <= i || starts0[i] - starts0[i-1] != P) begin bad++; $display("FAIL basic_spacing%0d: got %0d want %0d", i, starts0.size() > i ? starts0[i] - starts0[i-1] : -1, P); end
    end
    total++; if (dones0.size() < 4 || avt0.size() < 1 || avt0[0] != dones0[3] + 2) begin bad++; $display("FAIL basic_av_latency: got %0d want 2", (dones0.size() >= 4 && avt0.size() >= 1) ? avt0[0] - dones0[3] : -1); end
    total++; if (te0 !== 1'b0 || ov0 !== 1'b0) begin bad++; $display("FAIL basic_sticky: got te=%b ov=%b want 0 0", te0, ov0); end
    stop0();
  endtask

  task automatic test_saturate;
    logic [15:0] f [4];
    logic [15:0] g [4];
    logic [7:0] e1, e2;
    frames0.delete(); clear_mon0();
    for (int i = 0; i < 4; i++) begin f[i] = mkf(255); frames0.push_back(f[i]); end
    for (int i = 0; i < 4; i++) begin g[i] = 16'hF01F; frames0.push_back(g[i]); end
    e1 = ref_avg(f);
    e2 = ref_avg(g);
    @(negedge clk); en0 = 1'b1;
    for (int i = 0; i < 1200 && avt0.size() < 2; i++) @(negedge clk);
    total++; if (avt0.size() != 2) begin bad++; $display("FAIL sat_av_count: got %0d want 2", avt0.size()); end
    total++; if (avv0.size() < 1 || avv0[0] !== e1) begin bad++; $display("FAIL sat_avg_255: got %0d want %0d", avv0.size() ? avv0[0] : 8'd0, e1); end
    total++; if (avv0.size() < 2 || avv0[1] !== e2) begin bad++; $display("FAIL sat_avg_f01f: got %0h want %0h", avv0.size() > 1 ? avv0[1] : 8'd0, e2); end
    stop0();
  endtask

  task automatic test_timeout;
    logic [15:0] f [4];
    logic [7:0] exp;
    frames0.delete(); clear_mon0();
    for (int i = 0; i < 4; i++) begin f[i] = mkf(int'($urandom_range(0, 255))); frames0.push_back(f[i]); end
    exp = ref_avg(f);
    total++; if (te0 !== 1'b0) begin bad++; $display("FAIL to_err_before: got %b want 0", te0); end
    withhold0 = 1;
    @(negedge clk); en0 = 1'b1;
    for (int i = 0; i < 1000 && avt0.size() < 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++; if (starts0.size() < 1 || busyfall0.size() < 1 || busyfall0[0] != starts0[0] + TO) begin bad++; $display("FAIL to_busy_fall: got %0d want %0d", (starts0.size() && busyfall0.size()) ? busyfall0[0] - starts0[0] : -1, TO); end
    total++; if (te0 !== 1'b1) begin bad++; $display("FAIL to_err_set: got %b want 1", te0); end
    total++; if (starts0.size() != 5 || dones0.size() != 4) begin bad++; $display("FAIL to_counts: got starts=%0d dones=%0d want 5 4", starts0.size(), dones0.size()); end
    total++; if (avv0.size() != 1 || avv0[0] !== exp) begin bad++; $display("FAIL to_avg: got n=%0d v=%0d want n=1 v=%0d", avv0.size(), avv0.size() ? avv0[0] : 8'd0, exp); end
    total++; if (dones0.size() < 4 || avt0.size() < 1 || avt0[0] != dones0[3] + 2) begin bad++; $display("FAIL to_av_latency: got %0d want 2", (dones0.size() >= 4 && avt0.size()) ? avt0[0] - dones0[3] : -1); end
    stop0();
  endtask

  task automatic test_en_drop;
    logic [15:0] f [4];
    logic [7:0] exp;
    int c;
    frames0.delete(); clear_mon0();
    frames0.push_back(mkf(200));
    for (int i = 0; i < 4; i++) begin f[i] = mkf(int'($urandom_range(0, 100))); frames0.push_back(f[i]); end
    exp = ref_avg(f);
    @(negedge clk); en0 = 1'b1;
    for (int i = 0; i < 200 && starts0.size() < 1; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    en0 = 1'b0;
    repeat (300) @(negedge clk);
    total++; if (starts0.size() != 1) begin bad++; $display("FAIL drop_no_start: got %0d starts want 1", starts0.size()); end
    total++; if (dones0.size() != 1) begin bad++; $display("FAIL drop_done_taken: got %0d dones want 1", dones0.size()); end
    total++; if (avt0.size() != 0) begin bad++; $display("FAIL drop_no_publish: got %0d want 0", avt0.size()); end
    clear_mon0();
    en0 = 1'b1; c = cyc;
    for (int i = 0; i < 800 && avt0.size() < 1; i++) @(negedge clk);
    total++; if (starts0.size() < 1 || starts0[0] != c + P + 1) begin bad++; $display("FAIL drop_restart: got %0d want %0d", starts0.size() ? starts0[0] - c : -1, P + 1); end
    total++; if (avv0.size() != 1 || avv0[0] !== exp) begin bad++; $display("FAIL drop_fresh_avg: got %0d want %0d", avv0.size() ? avv0[0] : 8'd0, exp); end
    stop0();
  endtask

  task automatic test_overrun;
    starts1.delete();
    total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL ovr_before: got %b want 0", ov1); end
    @(negedge clk); en1 = 1'b1;
    for (int i = 0; i < 200 && starts1.size() < 1; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL ovr_early: got %b want 0", ov1); end
    for (int i = 0; i < 800 && starts1.size() < 3; i++) @(negedge clk);
    total++; if (ov1 !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", ov1); end
    total++; if (te1 !== 1'b0) begin bad++; $display("FAIL ovr_no_timeout: got %b want 0", te1); end
    for (int i = 1; i < 3; i++) begin
      total++; if (starts1.size() <= i || starts1[i] - starts1[i-1] != 2 * P) begin bad++; $display("FAIL ovr_spacing%0d: got %0d want %0d", i, starts1.size() > i ? starts1[i] - starts1[i-1] : -1, 2 * P); end
    end
    en1 = 1'b0;
    repeat (200) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int c;
    frames0.delete(); clear_mon0();
    @(negedge clk); en0 = 1'b1;
    for (int i = 0; i < 200 && starts0.size() < 1; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (busy0 !== 1'b0 || bus0.start !== 1'b0 || av0 !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl: got busy=%b start=%b av=%b want 0 0 0", busy0, bus0.start, av0); end
    total++; if (avg0 !== 8'd0) begin bad++; $display("FAIL rstmid_avg: got %0d want 0", avg0); end
    total++; if (te0 !== 1'b0 || ov1 !== 1'b0) begin bad++; $display("FAIL rstmid_sticky: got te=%b ov=%b want 0 0", te0, ov1); end
    repeat (3) @(negedge clk);
    rst = 1'b1; c = cyc;
    clear_mon0();
    for (int i = 0; i < 300 && starts0.size() < 1; i++) @(negedge clk);
    total++; if (starts0.size() < 1 || starts0[0] != c + P + 1) begin bad++; $display("FAIL rstmid_resume: got %0d want %0d", starts0.size() ? starts0[0] - c : -1, P + 1); end
    stop0();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_timeout();
    test_en_drop();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/als_sample_sequencer.md
# als_sample_sequencer

Periodic sampling sequencer for the PmodALS SPI read path. Issues a conversion request to `controller_PmodALS` every `SAMPLE_PERIOD` clocks while enabled and extracts the 8-bit light value from each 16-bit frame. Averages 2^`AVG_LOG2` consecutive samples and publishes the result with a one-cycle strobe. Sits between the board switch/enable logic and the SPI controller, and owns all conversion scheduling.

## Interface
- `SAMPLE_PERIOD`, 100000: clocks between conversion starts; must be ≥ `TIMEOUT` + 4.
- `AVG_LOG2`, 2: log2 of the number of samples averaged, range 0..6.
- `TIMEOUT`, 4096: maximum clocks from `start` to `done` before the attempt is abandoned.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: sampling enable (the board switch).
- `done` in 1: one-cycle pulse from the SPI controller; `frame` is valid in that cycle.
- `frame` in 16: raw SPI frame. The sample is `frame[12:5]`; all other bits are ignored.
- `start` out 1: one-cycle conversion request to the SPI controller.
- `avg` out 8: latest published average; held between updates.
- `avg_valid` out 1: one-cycle strobe, asserted in the cycle `avg` updates.
- `busy` out 1: high from `start` until the matching `done` or timeout.
- `timeout_err` out 1: sticky; set on timeout, cleared only by reset.
- `overrun` out 1: sticky; set when a period tick occurs while `busy`, cleared only by reset.

## Operation
- FSM states:
  - IDLE: waits for `en`=1, then goes to WAIT_TICK.
  - WAIT_TICK: on a period tick, goes to REQ.
  - REQ: pulses `start` and goes to WAIT_DONE.
  - WAIT_DONE: on `done`, goes to ACCUM; on timeout, goes to WAIT_TICK.
  - ACCUM: adds the sample and increments the sample count. If the count reaches 2^`AVG_LOG2`, goes to PUBLISH; otherwise to WAIT_TICK.
  - PUBLISH: updates `avg`, pulses `avg_valid`, clears the accumulator and count, then goes to WAIT_TICK.
- Period counter:
  - Runs only while `en`=1. Loads `SAMPLE_PERIOD`-1 when leaving IDLE and counts down.
  - A tick is the cycle the counter reaches 0. The counter reloads on the same cycle.
  - The first tick therefore occurs `SAMPLE_PERIOD` clocks after `en` is seen.
- Accumulator: width 8+`AVG_LOG2`, unsigned, cannot overflow. `avg` = accumulator >> `AVG_LOG2` (truncating).
- A tick while `busy` is dropped and sets `overrun`. No request is queued.
- Timeout:
  - The watchdog starts at `start` and fires when `TIMEOUT` clocks pass without `done`.
  - On timeout: the sample is discarded, the accumulator is kept, and `timeout_err` is set.
  - A late `done` arriving outside WAIT_DONE is ignored.
- `en` falling:
  - In WAIT_TICK, REQ or WAIT_DONE: no further `start` is issued.
  - A conversion already started is still awaited (`done` or timeout) so the SPI transaction is never abandoned. Its sample is discarded.
  - The FSM then enters IDLE and clears the accumulator, count and period counter. `avg` is held.
- `en` rising again: restarts from an empty accumulator with a full period.
- A `done` coinciding with a tick in WAIT_DONE: accept `done` and drop the tick (counts as overrun).

## Timing
- Reset values: `start`=0, `busy`=0, `avg`=0, `avg_valid`=0, `timeout_err`=0, `overrun`=0, FSM=IDLE, counters=0.
- Tick to `start`: 1 cycle. `busy` rises with `start`.
- `done` to sample in the accumulator: 1 cycle (ACCUM).
- Last `done` to `avg_valid`: 2 cycles. `avg` is valid in the same cycle as `avg_valid`.
- `busy` falls the cycle after `done`, or the cycle after timeout.
- Reset mid-conversion: all state clears immediately. The SPI controller is assumed to be reset by the same `rst`.

## Structure
- Shared package `als_pkg`:
  - FSM state enum.
  - Frame field constants `ALS_MSB`=12 and `ALS_LSB`=5.
  - Sample width constant `ALS_W`=8.
- One natural sub-module, `als_period_timer`: the period down-counter with `en`/reload and tick output.
- The watchdog lives in the main FSM module.

## Test plan
Bench: `SAMPLE_PERIOD`=100, `AVG_LOG2`=2, `TIMEOUT`=64, with an SPI controller model that returns `done` 40 clocks after `start`.
- Frames with samples 10, 20, 30, 40 → `avg`=25 and a single `avg_valid`, 2 cycles after the 4th `done`; `start` spaced exactly 100 clocks.
- Four samples of 255 → `avg`=255, no wrap. Then frame 16'hF01F ×4 → `avg`=0x80 (only bits [12:5] used).
- Model withholds `done` once → `busy` drops 64 clocks after `start`, `timeout_err`=1, no sample counted; the next 4 good samples publish normally.
- `en`=0 while in WAIT_DONE → no further `start`; the pending `done` is accepted and discarded; `en`=1 → first `start` 100+1 clocks later, fresh average.
- Model delays `done` to 120 clocks (`TIMEOUT` raised for this case) → `overrun`=1, one tick dropped, no double `start`.
- `rst` asserted mid-WAIT_DONE → all outputs 0 the same cycle; resumes from IDLE after release.
